// File: rtl/search_pkg.sv
// Shared parameter defaults and FSM encoding for the two-core search dispatcher.
package search_pkg;

  localparam int unsigned SEQ_WIDTH_DEF = 8;
  localparam int unsigned E_WIDTH_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/search_lane.sv
// One core's issue slot: holds an offered sequence until taken, then tracks the
// outstanding result and remembers which sequence it belongs to.
module search_lane
  import search_pkg::*;
#(
  parameter int unsigned SEQ_WIDTH = SEQ_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_i,
  input  logic [SEQ_WIDTH-1:0] issue_seq_i,
  input  logic                 flush_i,
  input  logic                 idle_done_i,
  input  logic                 core_ready_i,
  input  logic                 res_valid_i,
  output logic [SEQ_WIDTH-1:0] seq_o,
  output logic                 valid_o,
  output logic                 ready_o,
  output logic                 pend_o,
  output logic                 free_c_o,
  output logic                 xfer_c_o,
  output logic                 acc_c_o
);

  logic                 valid_q, valid_d;
  logic                 pending_q, pending_d;
  logic                 ready_q, ready_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;

  assign free_c_o = ~valid_q & ~pending_q;
  assign xfer_c_o = valid_q & core_ready_i;
  assign acc_c_o  = res_valid_i & ready_q & pending_q;

  always_comb begin
    valid_d   = valid_q;
    pending_d = pending_q;
    seq_d     = seq_q;
    if (xfer_c_o) begin
      valid_d   = 1'b0;
      pending_d = 1'b1;
    end
    if (acc_c_o) pending_d = 1'b0;
    if (issue_i) begin
      valid_d = 1'b1;
      seq_d   = issue_seq_i;
    end
    if (flush_i) begin
      valid_d   = 1'b0;
      pending_d = 1'b0;
    end
    // Outside a sweep the lane swallows any stale result.
    ready_d = pending_d | idle_done_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      seq_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      seq_q     <= seq_d;
    end
  end

  assign seq_o   = seq_q;
  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign pend_o  = pending_q;

endmodule

// File: rtl/search_dispatch.sv
// Sweeps a sequence range across two compute cores and keeps the lowest-energy
// result together with the sequence that produced it.
module search_dispatch
  import search_pkg::*;
#(
  parameter int unsigned SEQ_WIDTH = SEQ_WIDTH_DEF,
  parameter int unsigned E_WIDTH   = E_WIDTH_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [SEQ_WIDTH-1:0] i_first,
  input  logic [SEQ_WIDTH-1:0] i_last,
  output logic [SEQ_WIDTH-1:0] o_s00_seq,
  output logic                 o_s00_valid,
  input  logic                 i_s00_ready,
  input  logic [E_WIDTH-1:0]   i_s00_e,
  input  logic                 i_s00_valid,
  output logic                 o_s00_ready,
  output logic [SEQ_WIDTH-1:0] o_s01_seq,
  output logic                 o_s01_valid,
  input  logic                 i_s01_ready,
  input  logic [E_WIDTH-1:0]   i_s01_e,
  input  logic                 i_s01_valid,
  output logic                 o_s01_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [E_WIDTH-1:0]   o_best_e,
  output logic [SEQ_WIDTH-1:0] o_best_seq,
  output logic                 o_best_valid
);

  localparam int unsigned CW = SEQ_WIDTH + 1;

  state_e               state_q, state_d;
  logic [SEQ_WIDTH-1:0] next_q;
  logic [CW-1:0]        issue_left_q, xfer_left_q;
  logic                 rr_q, busy_q, done_q, best_valid_q;
  logic [E_WIDTH-1:0]   best_e_q;
  logic [SEQ_WIDTH-1:0] best_seq_q;

  logic                 free0, free1, xfer0, xfer1, acc0, acc1, pend0, pend1;
  logic                 start_acc, abort_acc, can_issue, issue0, issue1;
  logic                 idle_done_c, pick1, best_upd;
  logic [SEQ_WIDTH-1:0] span_c, cand_seq;
  logic [E_WIDTH-1:0]   cand_e;
  logic [CW-1:0]        n_xfer_c;

  always_comb begin
    start_acc = i_start & ~i_abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    abort_acc = i_abort & ((state_q == ST_RUN) | (state_q == ST_DRAIN));
    span_c    = i_last - i_first;
    n_xfer_c  = CW'(xfer0) + CW'(xfer1);
    can_issue = (state_q == ST_RUN) & (issue_left_q != '0) & ~abort_acc;
    // Round-robin only matters when both cores are free.
    issue0    = can_issue & free0 & (~free1 | ~rr_q);
    issue1    = can_issue & free1 & (~free0 | rr_q);

    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_acc) state_d = ST_RUN;
      ST_RUN: begin
        if (abort_acc) state_d = ST_IDLE;
        else if ((n_xfer_c != '0) && (xfer_left_q == n_xfer_c)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_acc) state_d = ST_IDLE;
        else if (~pend0 & ~pend1) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    idle_done_c = (state_d == ST_IDLE) | (state_d == ST_DONE);

    // Same-cycle results: core 0 wins ties, then the candidate must strictly beat best.
    pick1    = acc1 & (~acc0 | (i_s01_e < i_s00_e));
    cand_e   = pick1 ? i_s01_e : i_s00_e;
    cand_seq = pick1 ? o_s01_seq : o_s00_seq;
    best_upd = (acc0 | acc1) & ~abort_acc & (~best_valid_q | (cand_e < best_e_q));
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      next_q       <= '0;
      issue_left_q <= '0;
      xfer_left_q  <= '0;
      rr_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_valid_q <= 1'b0;
      best_e_q     <= '0;
      best_seq_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN) | (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_DONE);
      if (start_acc) begin
        next_q       <= i_first;
        issue_left_q <= {1'b0, span_c} + CW'(1);
        xfer_left_q  <= {1'b0, span_c} + CW'(1);
        rr_q         <= 1'b0;
        best_valid_q <= 1'b0;
        best_e_q     <= '0;
        best_seq_q   <= '0;
      end else begin
        if (issue0 | issue1) begin
          next_q       <= next_q + SEQ_WIDTH'(1);
          issue_left_q <= issue_left_q - CW'(1);
          rr_q         <= ~rr_q;
        end
        xfer_left_q <= xfer_left_q - n_xfer_c;
        if (best_upd) begin
          best_valid_q <= 1'b1;
          best_e_q     <= cand_e;
          best_seq_q   <= cand_seq;
        end
      end
    end
  end

  search_lane #(.SEQ_WIDTH(SEQ_WIDTH)) u_lane0 (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .issue_i(issue0), .issue_seq_i(next_q),
    .flush_i(abort_acc), .idle_done_i(idle_done_c), .core_ready_i(i_s00_ready),
    .res_valid_i(i_s00_valid), .seq_o(o_s00_seq), .valid_o(o_s00_valid),
    .ready_o(o_s00_ready), .pend_o(pend0), .free_c_o(free0), .xfer_c_o(xfer0),
    .acc_c_o(acc0)
  );

  search_lane #(.SEQ_WIDTH(SEQ_WIDTH)) u_lane1 (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .issue_i(issue1), .issue_seq_i(next_q),
    .flush_i(abort_acc), .idle_done_i(idle_done_c), .core_ready_i(i_s01_ready),
    .res_valid_i(i_s01_valid), .seq_o(o_s01_seq), .valid_o(o_s01_valid),
    .ready_o(o_s01_ready), .pend_o(pend1), .free_c_o(free1), .xfer_c_o(xfer1),
    .acc_c_o(acc1)
  );

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_best_e     = best_e_q;
  assign o_best_seq   = best_seq_q;
  assign o_best_valid = best_valid_q;

endmodule

// File: tb/tb_search_dispatch.sv
// Directed bench for search_dispatch with a small two-core responder model.
module tb_search_dispatch;

  localparam int unsigned SW = 8;
  localparam int unsigned EW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort;
  logic [SW-1:0] first, last;
  logic [SW-1:0] s0_seq, s1_seq;
  logic          s0_valid, s1_valid, s0_ready, s1_ready;
  logic          c_ready[2];
  logic          c_valid[2];
  logic [EW-1:0] c_e[2];
  logic          busy, done, best_valid;
  logic [EW-1:0] best_e;
  logic [SW-1:0] best_seq;

  int checks, errors;

  // responder model state
  bit            rdy_en[2];
  int            lat[2];
  int            cnt[2];
  bit            pend[2];
  logic [SW-1:0] pseq[2];
  bit            xf_pred[2];
  bit            ac_pred[2];
  logic [SW-1:0] xf_seq[2];
  int            acc_cnt[2];
  int            e_mode;
  logic [EW-1:0] e_const;
  logic [SW-1:0] log_seq[$];
  int            log_core[$];

  search_dispatch dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .i_start(start), .i_abort(abort),
    .i_first(first), .i_last(last),
    .o_s00_seq(s0_seq), .o_s00_valid(s0_valid), .i_s00_ready(c_ready[0]),
    .i_s00_e(c_e[0]), .i_s00_valid(c_valid[0]), .o_s00_ready(s0_ready),
    .o_s01_seq(s1_seq), .o_s01_valid(s1_valid), .i_s01_ready(c_ready[1]),
    .i_s01_e(c_e[1]), .i_s01_valid(c_valid[1]), .o_s01_ready(s1_ready),
    .o_busy(busy), .o_done(done), .o_best_e(best_e), .o_best_seq(best_seq),
    .o_best_valid(best_valid)
  );

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; c_valid[k] = 1'b0; c_e[k] = '0; cnt[k] = 0;
      xf_pred[k] = 1'b0; ac_pred[k] = 1'b0; acc_cnt[k] = 0;
    end
    log_seq.delete();
    log_core.delete();
  endtask

  // Advance to the next falling edge, apply what happened on the rising edge, drive cores.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (ac_pred[k]) begin
        c_valid[k] = 1'b0; pend[k] = 1'b0; acc_cnt[k]++;
      end
      if (xf_pred[k]) begin
        log_seq.push_back(xf_seq[k]); log_core.push_back(k);
        pend[k] = 1'b1; pseq[k] = xf_seq[k]; cnt[k] = lat[k];
      end
      c_ready[k] = rdy_en[k];
      if (pend[k] && !c_valid[k]) begin
        if (cnt[k] == 0) begin
          c_valid[k] = 1'b1;
          c_e[k] = (e_mode == 0) ? EW'(pseq[k]) * EW'(10) : e_const;
        end else cnt[k]--;
      end
    end
    xf_pred[0] = s0_valid & c_ready[0]; xf_seq[0] = s0_seq;
    xf_pred[1] = s1_valid & c_ready[1]; xf_seq[1] = s1_seq;
    ac_pred[0] = c_valid[0] & s0_ready;
    ac_pred[1] = c_valid[1] & s1_ready;
  endtask

  task automatic start_sweep(input logic [SW-1:0] f, input logic [SW-1:0] l);
    first = f; last = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    ok = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; first = '0; last = '0;
    rdy_en = '{1'b1, 1'b1}; lat = '{0, 0}; e_mode = 0; e_const = '0;
    clear_model();
    tick(); tick();
    checks++; if ({s1_ready, s0_ready, s1_valid, s0_valid} !== 4'b0000) begin
      errors++; $display("FAIL rst_hs got %b want 0000", {s1_ready, s0_ready, s1_valid, s0_valid}); end
    checks++; if ({busy, done, best_valid} !== 3'b000) begin
      errors++; $display("FAIL rst_flags got %b want 000", {busy, done, best_valid}); end
    checks++; if ({best_e, best_seq, s0_seq, s1_seq} !== '0) begin
      errors++; $display("FAIL rst_data got %h want 0", {best_e, best_seq, s0_seq, s1_seq}); end
    rst = 1'b0;
    tick();
    checks++; if ({s1_ready, s0_ready} !== 2'b11) begin
      errors++; $display("FAIL rst_release_ready got %b want 11", {s1_ready, s0_ready}); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [SW-1:0] es[4];
    int ec[4];
    es = '{8'h03, 8'h04, 8'h05, 8'h06};
    ec = '{0, 1, 0, 1};
    tick(); clear_model();
    start_sweep(8'h03, 8'h06);
    checks++; if ({busy, s1_valid, s0_valid} !== 3'b100) begin
      errors++; $display("FAIL basic_run_entry got %b want 100", {busy, s1_valid, s0_valid}); end
    tick();
    checks++; if ({s0_valid, s1_valid, s0_seq} !== {2'b10, 8'h03}) begin
      errors++; $display("FAIL basic_first_issue got %h want 203", {s0_valid, s1_valid, s0_seq}); end
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done got 0 want 1"); end
    checks++; if (log_seq.size() != 4) begin
      errors++; $display("FAIL basic_count got %0d want 4", log_seq.size()); end
    for (int i = 0; i < 4 && i < log_seq.size(); i++) begin
      checks++; if (log_seq[i] !== es[i] || log_core[i] != ec[i]) begin
        errors++; $display("FAIL basic_issue%0d got %h/core%0d want %h/core%0d",
                           i, log_seq[i], log_core[i], es[i], ec[i]); end
    end
    checks++; if ({best_valid, best_e, best_seq} !== {1'b1, 16'd30, 8'h03}) begin
      errors++; $display("FAIL basic_best got %0d/%h want 30/03", best_e, best_seq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [SW-1:0] es[4];
    es = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    tick(); clear_model();
    start_sweep(8'hFE, 8'h01);
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done got 0 want 1"); end
    checks++; if (log_seq.size() != 4) begin
      errors++; $display("FAIL wrap_count got %0d want 4", log_seq.size()); end
    for (int i = 0; i < 4 && i < log_seq.size(); i++) begin
      checks++; if (log_seq[i] !== es[i]) begin
        errors++; $display("FAIL wrap_issue%0d got %h want %h", i, log_seq[i], es[i]); end
    end
    checks++; if ({best_e, best_seq} !== {16'd0, 8'h00}) begin
      errors++; $display("FAIL wrap_best got %0d/%h want 0/00", best_e, best_seq); end
  endtask

  task automatic test_stall();
    bit ok;
    int n = 0;
    logic [SW-1:0] held;
    tick(); clear_model();
    rdy_en[1] = 1'b0;
    start_sweep(8'h00, 8'h07);
    while (!s1_valid && n < 10) begin tick(); n++; end
    held = s1_seq;
    checks++; if ({s1_valid, held} !== {1'b1, 8'h01}) begin
      errors++; $display("FAIL stall_issue got %h want 101", {s1_valid, held}); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if ({s1_valid, s1_seq} !== {1'b1, 8'h01}) begin
        errors++; $display("FAIL stall_hold%0d got %h want 101", i, {s1_valid, s1_seq}); end
    end
    checks++; if (log_seq.size() != 7) begin
      errors++; $display("FAIL stall_core0_progress got %0d want 7", log_seq.size()); end
    rdy_en[1] = 1'b1;
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done got 0 want 1"); end
    checks++; if (log_seq.size() != 8 || log_seq[log_seq.size()-1] !== 8'h01 ||
                  log_core[log_core.size()-1] != 1) begin
      errors++; $display("FAIL stall_last got n=%0d want 8 ending 01/core1", log_seq.size()); end
  endtask

  task automatic test_tie();
    bit ok;
    tick(); clear_model();
    e_mode = 1; e_const = 16'd5; lat = '{1, 0};
    start_sweep(8'h0A, 8'h0B);
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_done got 0 want 1"); end
    checks++; if ({best_valid, best_e, best_seq} !== {1'b1, 16'd5, 8'h0A}) begin
      errors++; $display("FAIL tie_best got %0d/%h want 5/0a", best_e, best_seq); end
    e_mode = 0; lat = '{0, 0};
  endtask

  task automatic test_abort();
    int n = 0;
    tick(); clear_model();
    lat = '{2, 2};
    start_sweep(8'd20, 8'd29);
    while (log_seq.size() < 2 && n < 10) begin tick(); n++; end
    checks++; if (log_seq.size() != 2) begin
      errors++; $display("FAIL abort_issues got %0d want 2", log_seq.size()); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if ({busy, done, s1_valid, s0_valid} !== 4'b0000) begin
      errors++; $display("FAIL abort_idle got %b want 0000", {busy, done, s1_valid, s0_valid}); end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (acc_cnt[0] != 1 || acc_cnt[1] != 1) begin
      errors++; $display("FAIL abort_stale_accept got %0d/%0d want 1/1", acc_cnt[0], acc_cnt[1]); end
    checks++; if ({s1_ready, s0_ready, best_valid} !== 3'b110) begin
      errors++; $display("FAIL abort_best got %b want 110", {s1_ready, s0_ready, best_valid}); end
    checks++; if (log_seq.size() != 2) begin
      errors++; $display("FAIL abort_no_issue got %0d want 2", log_seq.size()); end
    first = 8'd0; last = 8'd1; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    checks++; if ({busy, s1_valid, s0_valid} !== 3'b000) begin
      errors++; $display("FAIL abort_wins got %b want 000", {busy, s1_valid, s0_valid}); end
    lat = '{0, 0};
  endtask

  task automatic test_reset_drain();
    bit ok;
    int n = 0;
    tick(); clear_model();
    lat = '{0, 6};
    start_sweep(8'd40, 8'd42);
    while (!(log_seq.size() == 3 && best_valid && busy && !s0_valid && !s1_valid) && n < 20) begin
      tick(); n++;
    end
    checks++; if (n >= 20) begin errors++; $display("FAIL drain_reach got timeout want drain"); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, best_valid, s1_valid, s0_valid, s1_ready, s0_ready} !== 7'b0) begin
      errors++; $display("FAIL drain_rst_flags got %b want 0", {busy, done, best_valid, s1_valid, s0_valid, s1_ready, s0_ready}); end
    checks++; if ({best_e, best_seq, s0_seq, s1_seq} !== '0) begin
      errors++; $display("FAIL drain_rst_data got %h want 0", {best_e, best_seq, s0_seq, s1_seq}); end
    clear_model();
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if ({s1_ready, s0_ready} !== 2'b11) begin
      errors++; $display("FAIL drain_release_ready got %b want 11", {s1_ready, s0_ready}); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if ({busy, s1_valid, s0_valid} !== 3'b000 || log_seq.size() != 0) begin
      errors++; $display("FAIL drain_no_issue got %b n=%0d want 000 n=0", {busy, s1_valid, s0_valid}, log_seq.size()); end
    lat = '{0, 0};
    start_sweep(8'd50, 8'd50);
    wait_done(30, ok);
    checks++; if (!ok || {best_valid, best_e, best_seq} !== {1'b1, 16'd500, 8'd50}) begin
      errors++; $display("FAIL drain_restart got %0d/%0d want 500/50", best_e, best_seq); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_tie();
    test_abort();
    test_reset_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
